// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and latency bounds for the memory read arbiter
//
// Purpose: channel id enum, in-flight tag struct and the legal RD_LAT range,
//          imported by rr_arb2 and mem_rd_arbiter.
// Ports:   none (package).
package mem_arb_pkg;

  // Channel identity; CH1 = instruction fetch, CH2 = data load.
  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } ch_id_e;

  // One entry of the read-tag pipeline.
  typedef struct packed {
    logic   valid;
    ch_id_e owner;
  } tag_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with last-grant pointer
//
// Purpose: grants at most one of two requesters per cycle; on contention the
//          channel not granted most recently wins.
// Ports:   clk    - clock, rising edge
//          rst_n  - asynchronous active-low reset
//          req    - request vector, bit 0 = CH1, bit 1 = CH2
//          gnt    - grant vector, one-hot or zero, combinational from req
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  ch_id_e last_q;
  ch_id_e last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == CH2) ? 2'b01 : 2'b10;
    end
  end

  // Pointer only moves when something is granted; idle cycles keep history.
  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = CH1;
    end else if (gnt[1]) begin
      last_d = CH2;
    end
  end

  // Reset to "CH2 last" so CH1 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CH2;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin share of one synchronous-read memory port between two read channels
//
// Purpose: arbitrates RCH1/RCH2 onto MEM_EN/MEM_ADDR, tracks the owner of each
//          in-flight read in an RD_LAT-deep tag pipeline and steers MEM_DATA
//          back with a per-channel valid strobe.
// Ports:   CLK, RSTN                      - clock, async active-low reset
//          RCHx_REQ, RCHx_ADDR            - channel read request and byte address
//          RCHx_GNT                       - request accepted this cycle (stall when 0)
//          RCHx_VALID, RCHx_DATA          - returned read data strobe and data
//          MEM_EN, MEM_ADDR, MEM_DATA     - memory port; data RD_LAT cycles after MEM_EN
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              RCH1_REQ,
  input  logic [ADDR_W-1:0] RCH1_ADDR,
  output logic              RCH1_GNT,
  output logic              RCH1_VALID,
  output logic [DATA_W-1:0] RCH1_DATA,
  input  logic              RCH2_REQ,
  input  logic [ADDR_W-1:0] RCH2_ADDR,
  output logic              RCH2_GNT,
  output logic              RCH2_VALID,
  output logic [DATA_W-1:0] RCH2_DATA,
  output logic              MEM_EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_rd_arbiter: RD_LAT must be within 1..4");
  end

  logic [1:0] req;
  logic [1:0] gnt;

  // Requests are masked while reset is asserted so nothing is granted then.
  assign req = {RCH2_REQ, RCH1_REQ} & {2{RSTN}};

  rr_arb2 u_rr_arb2 (
    .clk   (CLK),
    .rst_n (RSTN),
    .req   (req),
    .gnt   (gnt)
  );

  assign RCH1_GNT = gnt[0];
  assign RCH2_GNT = gnt[1];
  assign MEM_EN   = |gnt;

  always_comb begin
    MEM_ADDR = '0;
    if (gnt[0]) begin
      MEM_ADDR = RCH1_ADDR;
    end else if (gnt[1]) begin
      MEM_ADDR = RCH2_ADDR;
    end
  end

  // Tag pipeline: stage 0 captures this cycle's grant, later stages age it so
  // the last stage lines up with MEM_DATA for that read.
  tag_t [RD_LAT-1:0] tag_q;
  tag_t [RD_LAT-1:0] tag_d;

  always_comb begin
    tag_d          = tag_q;
    tag_d[0].valid = MEM_EN;
    tag_d[0].owner = gnt[1] ? CH2 : CH1;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Clearing every stage drops reads that were in flight at reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  tag_t ret_tag;
  assign ret_tag = tag_q[RD_LAT-1];

  assign RCH1_VALID = ret_tag.valid && (ret_tag.owner == CH1);
  assign RCH2_VALID = ret_tag.valid && (ret_tag.owner == CH2);
  assign RCH1_DATA  = MEM_DATA;
  assign RCH2_DATA  = MEM_DATA;

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Shares the single synchronous-read memory port between two read channels: RCH1 (core instruction fetch) and RCH2 (core data load). Arbitration is round-robin, one grant per cycle. The block tracks which channel owns each in-flight read through a tag pipeline of depth RD_LAT and steers the returning data to the right channel with a valid strobe. It sits between `core` and the memory model/SRAM.

## Interface
- ADDR_W, 32, address width of channels and memory port
- DATA_W, 32, read data width
- RD_LAT, 1, memory read latency in cycles (legal 1..4)
- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset; asynchronous, active-low
- RCH1_REQ  in  1  channel 1 read request, held until granted
- RCH1_ADDR  in  ADDR_W  channel 1 byte address, stable while REQ high
- RCH1_GNT  out  1  channel 1 request accepted this cycle
- RCH1_VALID  out  1  RCH1_DATA holds channel 1 read data this cycle
- RCH1_DATA  out  DATA_W  channel 1 read data
- RCH2_REQ, RCH2_ADDR, RCH2_GNT, RCH2_VALID, RCH2_DATA: same as channel 1, for channel 2
- MEM_EN  out  1  memory read enable
- MEM_ADDR  out  ADDR_W  memory byte address
- MEM_DATA  in  DATA_W  memory read data, valid RD_LAT cycles after MEM_EN is sampled

## Operation
- Grant logic (combinational from REQ and the rr pointer):
  - Only one requester: grant it.
  - Both requesting: grant the channel not granted most recently.
  - No requester: no grant, MEM_EN=0.
- rr pointer:
  - Updates on every cycle with a grant; it records the granted channel.
  - Reset value records channel 2 as last granted, so channel 1 wins the first contention.
- MEM_EN = RCH1_GNT | RCH2_GNT. MEM_ADDR is the granted channel's address. When idle, MEM_ADDR holds 0.
- Tag pipeline:
  - RD_LAT stages, each holding {valid, owner}.
  - Stage 0 loads {MEM_EN, granted channel} every cycle. Each later stage shifts from the previous one.
- Return path:
  - RCHx_VALID = last stage valid & (owner==x).
  - RCH1_DATA and RCH2_DATA both carry MEM_DATA, which is meaningful only while the matching VALID is high.
- Exactly one VALID per grant, in grant order. Both channels are never valid in the same cycle.
- A requester that is not granted keeps REQ high with ADDR stable. It sees GNT=0, which it uses as its stall.
- No backpressure on the return path: channels must accept VALID data in the cycle it appears.
- Back-to-back grants to the same channel are allowed every cycle when the other channel is idle. Throughput is 1 read/cycle.

## Timing
- Reset (RSTN low, asynchronous):
  - All tag stages are cleared.
  - rr pointer goes to its reset value.
  - RCHx_VALID=0. GNT and MEM_EN are 0 because no requests are honoured while RSTN is low.
- Reads in flight at reset assertion are dropped: no VALID is produced for them after RSTN rises.
- Request granted in cycle N:
  - MEM_ADDR is sampled by memory at the end of N.
  - RCHx_VALID is high in cycle N+RD_LAT.
- Simultaneous requests in cycle N: one grant in N. The loser is granted in N+1 if it still requests, whatever the winner does.
- Grant and return in the same cycle, same or different channel: both happen. Pipeline occupancy never blocks a grant.
- RD_LAT is fixed at elaboration. Values outside 1..4 are an elaboration error.

## Structure
- Package mem_arb_pkg:
  - Typedef for channel id (enum CH1, CH2).
  - Typedef for tag struct {valid, owner}.
  - Constant bounds for RD_LAT.
- One sub-module, rr_arb2: 2-way round-robin arbiter with pointer register. Inputs req[1:0], outputs gnt[1:0].
- The top level holds the address mux, the tag shift register, and the valid decode.

## Test plan
- Reset, no requests:
  - All GNT/VALID/MEM_EN are 0 throughout.
  - Release RSTN, then RCH1_REQ with ADDR 0x10 and mem[4]=0xDEADBEEF, RD_LAT=1 → RCH1_GNT in cycle N, RCH1_VALID with data 0xDEADBEEF in N+1.
- Contention:
  - Setup: both REQ held high for 4 cycles; ADDR1=0x0, ADDR2=0x40.
  - Required: grants alternate CH1,CH2,CH1,CH2; VALIDs return in the same order with mem[0] and mem[16].
- Streaming:
  - Setup: RCH1 requests 8 consecutive words 0x0..0x1C, RCH2 idle.
  - Required: 8 grants in 8 cycles and 8 VALIDs, in order, with no gaps.
- RD_LAT=3:
  - Stimulus: interleaved grants CH2,CH1,CH2.
  - Required: VALIDs appear 3 cycles after each grant, with correct owner and data.
- Reset mid-flight:
  - Setup: RD_LAT=3; assert RSTN low one cycle after two grants.
  - Required: VALID drops immediately, and no VALID appears after release until new grants are issued.
- Fairness after reset:
  - Setup: the first contention cycle after reset.
  - Required: CH1 wins; the next contention goes to CH2.
